// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared ALU opcode definitions
package alu_op_sequencer_pkg;

  localparam int ALU_OP_W     = 3;
  localparam int ALU_OP_COUNT = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  function automatic logic op_is_legal(input alu_op_t op);
    return op < ALU_OP_W'(ALU_OP_COUNT);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_fifo.sv
// rtl/alu_op_sequencer_fifo.sv - command FIFO with flush, power-of-two depth
module alu_cmd_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage is not reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - queues ALU commands and drives a stallable registered ALU interface
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic                flush,
  input  logic                alu_stall,
  output logic [DATA_W-1:0]   operand_1,
  output logic [DATA_W-1:0]   operand_2,
  output logic [ALU_OP_W-1:0] operation,
  output logic                op_valid,
  output logic                err_illegal,
  output logic [15:0]         issued_count,
  output logic [7:0]          illegal_count
);

  localparam int CMD_W = 2 * DATA_W + ALU_OP_W;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] head;
  logic             accept;
  logic             legal;
  logic             push;
  logic             load;
  logic             pop;

  // Ready depends only on registered occupancy and reset, never on the stall input.
  assign in_ready = rst_n && !fifo_full;
  assign accept   = in_valid && in_ready && !flush;
  assign legal    = op_is_legal(in_op);
  assign push     = accept && legal;
  assign load     = !op_valid || !alu_stall;
  assign pop      = load && !fifo_empty && !flush;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data ({in_a, in_b, in_op}),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      operand_1     <= '0;
      operand_2     <= '0;
      operation     <= '0;
      op_valid      <= 1'b0;
      err_illegal   <= 1'b0;
      issued_count  <= '0;
      illegal_count <= '0;
    end else begin
      err_illegal <= accept && !legal;
      if (accept && !legal && illegal_count != 8'hFF) illegal_count <= illegal_count + 8'd1;
      if (op_valid && !alu_stall) issued_count <= issued_count + 16'd1;
      if (flush) begin
        op_valid <= 1'b0;
      end else if (load) begin
        op_valid <= !fifo_empty;
        if (!fifo_empty) {operand_1, operand_2, operation} <= head;
      end
    end
  end

endmodule
